// File: rtl/minuart_tx.sv
// rtl/minuart_tx.sv - minuart serial transmitter: start, 8 data LSB-first, optional even parity, stop bits
// Optional parity bit compiled in with `define MINUART_TX_PARITY_EN.
module minuart_tx #(
  parameter int TICKS_PER_BIT = 16,
  parameter int STOP_BITS     = 1
) (
  input  logic       line_clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_pop,
  output logic       tx_pin,
  output logic       busy
);

  localparam int TW = $clog2(TICKS_PER_BIT);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

`ifdef MINUART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state, state_n;
  logic [TW-1:0]   tick, tick_n;
  logic [2:0]      bit_idx, bit_n;
  logic            stop_idx, stop_n;
  logic [7:0]      shreg, shreg_n;
  logic            load;
  logic            tx_n, pop_n, busy_n;
  logic            tick_last, launch;
`ifdef MINUART_TX_PARITY_EN
  logic            par_bit, par_n;
`endif

  assign tick_last = (tick == TICK_LAST);
  assign launch    = enable && !fifo_empty;

  always_ff @(posedge line_clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tick     <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      tx_pin   <= 1'b1;
      fifo_pop <= 1'b0;
      busy     <= 1'b0;
`ifdef MINUART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      tick     <= tick_n;
      bit_idx  <= bit_n;
      stop_idx <= stop_n;
      shreg    <= shreg_n;
      tx_pin   <= tx_n;
      fifo_pop <= pop_n;
      busy     <= busy_n;
`ifdef MINUART_TX_PARITY_EN
      par_bit  <= par_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    tick_n  = tick;
    bit_n   = bit_idx;
    stop_n  = stop_idx;
    shreg_n = shreg;
    load    = 1'b0;
`ifdef MINUART_TX_PARITY_EN
    par_n   = par_bit;
`endif
    if (state != IDLE) tick_n = tick_last ? '0 : tick + 1'b1;
    case (state)
      IDLE:  if (launch) load = 1'b1;
      START: if (tick_last) begin
        state_n = DATA;
        bit_n   = '0;
      end
      DATA: if (tick_last) begin
        shreg_n = {1'b0, shreg[7:1]};
        if (bit_idx == 3'd7) begin
`ifdef MINUART_TX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
          stop_n = 1'b0;
        end else begin
          bit_n = bit_idx + 3'd1;
        end
      end
`ifdef MINUART_TX_PARITY_EN
      PARITY: if (tick_last) begin
        state_n = STOP;
        stop_n  = 1'b0;
      end
`endif
      STOP: if (tick_last) begin
        if (stop_idx == STOP_LAST) begin
          // back-to-back frames relaunch on the last stop tick with no idle gap
          if (launch) load = 1'b1;
          else        state_n = IDLE;
        end else begin
          stop_n = stop_idx + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (load) begin
      state_n = START;
      tick_n  = '0;
      bit_n   = '0;
      stop_n  = 1'b0;
      shreg_n = fifo_data;
`ifdef MINUART_TX_PARITY_EN
      par_n   = ^fifo_data;
`endif
    end
  end

  // outputs are registered from the next-state view so tx_pin only moves on tick wraps
  always_comb begin
    pop_n  = load;
    busy_n = (state_n != IDLE);
    case (state_n)
      START:  tx_n = 1'b0;
      DATA:   tx_n = shreg_n[0];
`ifdef MINUART_TX_PARITY_EN
      PARITY: tx_n = par_bit;
`endif
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: doc/minuart_tx.md
# minuart_tx

Serial transmitter for the minuart peripheral, in the `line_clock` domain. It drains bytes from the transmit FIFO's read side and shifts each one out on `tx_pin` as an asynchronous serial frame. The frame format is start bit, 8 data bits LSB-first, optional parity, then stop bit(s). Each bit lasts `TICKS_PER_BIT` line clocks, matching the receiver's 16x oversampling.

## Interface
- `TICKS_PER_BIT`, 16: line_clock cycles per serial bit; legal range 2–256.
- `STOP_BITS`, 1: number of stop bits; legal values 1 or 2.
- `line_clock`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `enable`  input  1  transmit enable, driven by the config register bit and already synchronised into `line_clock`.
- `fifo_data`  input  8  head byte of the first-word-fall-through TX FIFO; valid whenever `fifo_empty` = 0.
- `fifo_empty`  input  1  TX FIFO has no data.
- `fifo_pop`  output  1  one-cycle read strobe to the TX FIFO.
- `tx_pin`  output  1  serial line; idle/mark = 1.
- `busy`  output  1  high while a frame is in progress.

## Operation
- **Reset values:** `tx_pin`=1, `fifo_pop`=0, `busy`=0, state IDLE, all counters 0. All outputs are registered.
- **States:** IDLE, START, DATA, PARITY (only when the macro is defined), STOP.
- **Counters:**
  - tick counter, 0..TICKS_PER_BIT-1.
  - bit index, 0..7.
  - stop index, 0..STOP_BITS-1.
  - 8-bit shift register.
- **IDLE:** `tx_pin`=1, `busy`=0.
  - Launch condition: `enable`=1 and `fifo_empty`=0 at a rising edge.
  - At that edge: load `fifo_data` into the shift register, pulse `fifo_pop`, go to START, `tx_pin`←0, `busy`←1, tick←0.
- **START:** `tx_pin`=0 for TICKS_PER_BIT cycles, then DATA with bit index 0.
- **DATA:** `tx_pin` = shift register bit 0.
  - At tick TICKS_PER_BIT-1: shift right.
  - Bit index increments; after index 7, go to PARITY or STOP.
- **PARITY:** `tx_pin` = XOR of the 8 data bits (even parity), held for one bit time.
- **STOP:** `tx_pin`=1 for STOP_BITS bit times.
  - On the final tick of the last stop bit, evaluate the launch condition.
  - If true: launch directly into START (back-to-back frames, no idle gap).
  - Otherwise: go to IDLE, `busy`←0.
- **`fifo_pop` rules:**
  - Asserted for exactly one cycle per frame.
  - Never asserted while `fifo_empty`=1.
  - Never asserted while `enable`=0.
- **`enable` deasserted mid-frame:** the current frame completes unaltered; no new launch until `enable`=1.
- **`fifo_empty` changes mid-frame:** no effect; only sampled at a launch decision.
- **`reset` asserted mid-frame:** `tx_pin` goes to 1 asynchronously; the frame is abandoned; the popped byte is lost.
- **Tick counter wrap:** wraps from TICKS_PER_BIT-1 to 0 at every bit boundary; no other state changes its period.

## Timing
- Launch latency: the edge that sees the launch condition is the same edge that sets `tx_pin`=0 and `fifo_pop`=1. `fifo_pop` drops on the next edge.
- Frame length, in line_clock cycles:
  - 8N1: 10·TICKS_PER_BIT (160 at the default).
  - With parity: 11·TICKS_PER_BIT.
  - With 2 stop bits: add TICKS_PER_BIT.
- Back-to-back frames: `fifo_pop` pulses spaced exactly one frame length apart; `tx_pin` has no extra idle cycles between frames.
- Each bit's level is held for exactly TICKS_PER_BIT cycles and changes only on a tick wrap edge. This makes `tx_pin` glitch-free.

## Configuration
- `MINUART_TX_PARITY_EN`:
  - **Defined:** the PARITY state is compiled in. An even-parity bit follows the data bits and the frame grows by one bit time.
  - **Undefined:** the PARITY state and its XOR logic are absent. DATA goes directly to STOP (8N1 / 8N2).

## Test plan
- **Single byte:** FIFO holds 0x55, `enable`=1, defaults → one `fifo_pop`; `tx_pin` sequence 0,1,0,1,0,1,0,1,0,1, each held 16 cycles; then `tx_pin`=1, `busy`=0 at cycle 160.
- **Back-to-back:** FIFO holds 0x00 then 0xFF → pops at cycles 0 and 160; `tx_pin` low 144 cycles (start + 0x00 data bits), high 16, low 16, high 144; `busy` stays high for 320 cycles.
- **Empty/disabled:** `fifo_empty`=1 with `enable`=1 for 1000 cycles → no pop, `tx_pin`=1; then a byte arrives with `enable`=0 → still no pop.
- **Enable drop:** drop `enable` at cycle 50 of a 0xA3 frame → frame completes bit-exact; no second pop even though the FIFO is non-empty.
- **Reset mid-frame:** assert `reset` at cycle 70 → `tx_pin`=1 immediately; after release with FIFO non-empty, the next frame starts one cycle later with a fresh start bit.
- **Parity and stop bits:** with `MINUART_TX_PARITY_EN` defined and STOP_BITS=2, byte 0x07 → parity bit 1 at cycles 144–159; stop bits high at cycles 160–191; the next pop is no earlier than cycle 192.
